// File: rtl/iic_wr_ctrl_pkg.sv
// Shared types for the SCCB/I2C register-write controller: FSM state and quarter
// encodings, the 3-byte frame payload, and the quarter-divider derivation.
package iic_wr_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SEND  = 2'd2,
        S_STOP  = 2'd3
    } iic_state_e;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quarter_e;

    localparam int unsigned BYTES_PER_XFER = 3;
    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned BIT_IDX_W      = 4;
    localparam int unsigned BYTE_IDX_W     = 2;

    // One register write as it appears on the wire, MSB first.
    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] ab;
        logic [7:0] db;
    } iic_frame_t;

    localparam int unsigned FRAME_W = $bits(iic_frame_t);

    function automatic int unsigned qdiv_calc(input int unsigned sys_clk_hz,
                                              input int unsigned scl_hz);
        return sys_clk_hz / (4 * scl_hz);
    endfunction

endpackage

// File: rtl/iic_wr_ctrl_qtick.sv
// Quarter-bit tick generator: counts 0..QDIV-1 while enabled, emits a registered
// tick in the last count of each quarter and tracks the quarter within the bit.
module iic_wr_ctrl_qtick
    import iic_wr_ctrl_pkg::*;
#(
    parameter int unsigned QDIV = 125
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en_i,
    input  logic     clr_i,
    output logic     tick_o,
    output quarter_e quarter_o
);

    localparam int unsigned CW = (QDIV > 2) ? $clog2(QDIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;
    quarter_e      quarter_q;

    // tick_q is pre-decoded one count early so it is high while cnt_q == QDIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            quarter_q <= Q0;
        end else if (clr_i) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            quarter_q <= Q0;
        end else if (en_i) begin
            cnt_q  <= tick_q ? '0 : cnt_q + CW'(1);
            tick_q <= (cnt_q == CW'(QDIV - 2));
            if (tick_q) begin
                quarter_q <= quarter_e'(quarter_q + 2'd1);
            end
        end
    end

    assign tick_o    = tick_q;
    assign quarter_o = quarter_q;

endmodule

// File: rtl/iic_wr_ctrl.sv
// Serialises one camera register write as START, DEV_ADDR, reg addr, data, STOP.
// Optional `ACK_CHECK_EN: samples each ACK slot and raises a sticky ack_err on NACK.
module iic_wr_ctrl
    import iic_wr_ctrl_pkg::*;
#(
    parameter int unsigned SYS_CLK_HZ = 50_000_000,
    parameter int unsigned SCL_HZ     = 100_000,
    parameter logic [7:0]  DEV_ADDR   = 8'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tiic_en,
    input  logic [7:0] tiic_ab,
    input  logic [7:0] tiic_db,
    output logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       done,
    output logic       ovr_err,
    output logic       ack_err
);

    localparam int unsigned QDIV = qdiv_calc(SYS_CLK_HZ, SCL_HZ);
    localparam logic [BIT_IDX_W-1:0]  BIT_TOP   = BIT_IDX_W'(BITS_PER_BYTE);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_XFER - 1);

    iic_state_e             state_q;
    logic [FRAME_W-1:0]     shift_q;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic [BYTE_IDX_W-1:0]  byte_idx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovr_err_q;
    logic                   scl_q;
    logic                   sda_lo_q;

    logic                   tick;
    quarter_e               quarter;
    logic                   q_end;
    logic                   scl_c;
    logic                   sda_lo_c;
    iic_frame_t             frame_c;

    iic_wr_ctrl_qtick #(
        .QDIV (QDIV)
    ) u_qtick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != S_IDLE),
        .clr_i     (state_q == S_IDLE),
        .tick_o    (tick),
        .quarter_o (quarter)
    );

    assign q_end       = tick && (quarter == Q3);
    assign frame_c.dev = DEV_ADDR;
    assign frame_c.ab  = tiic_ab;
    assign frame_c.db  = tiic_db;

    // Sequencer: a request is only accepted in IDLE outside the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= BIT_TOP;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tiic_en && (busy_q || done_q)) begin
                ovr_err_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (tiic_en && !done_q) begin
                        shift_q    <= frame_c;
                        bit_idx_q  <= BIT_TOP;
                        byte_idx_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (q_end) begin
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (q_end) begin
                        if (bit_idx_q != '0) begin
                            shift_q   <= {shift_q[FRAME_W-2:0], 1'b0};
                            bit_idx_q <= bit_idx_q - BIT_IDX_W'(1);
                        end else begin
                            bit_idx_q <= BIT_TOP;
                            if (byte_idx_q == LAST_BYTE) begin
                                state_q <= S_STOP;
                            end else begin
                                byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
                            end
                        end
                    end
                end
                S_STOP: begin
                    if (q_end) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Bus levels for the current quarter; bit_idx 0 is the ACK slot, left released.
    always_comb begin
        scl_c    = 1'b1;
        sda_lo_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                scl_c    = 1'b1;
                sda_lo_c = 1'b0;
            end
            S_START: begin
                scl_c    = (quarter != Q3);
                sda_lo_c = (quarter == Q2) || (quarter == Q3);
            end
            S_SEND: begin
                scl_c    = (quarter == Q1) || (quarter == Q2);
                sda_lo_c = (bit_idx_q != '0) && !shift_q[FRAME_W-1];
            end
            S_STOP: begin
                scl_c    = (quarter != Q0);
                sda_lo_c = (quarter == Q0) || (quarter == Q1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q    <= 1'b1;
            sda_lo_q <= 1'b0;
        end else begin
            scl_q    <= scl_c;
            sda_lo_q <= sda_lo_c;
        end
    end

    assign scl     = scl_q;
    assign sda     = sda_lo_q ? 1'b0 : 1'bz;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovr_err = ovr_err_q;

`ifdef ACK_CHECK_EN
    logic [1:0] sda_sync_q;
    logic       ack_err_q;

    // ACK is sampled at the end of q2, with SCL high for a full quarter already.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_sync_q <= 2'b11;
            ack_err_q  <= 1'b0;
        end else begin
            sda_sync_q <= {sda_sync_q[0], sda};
            if ((state_q == S_SEND) && tick && (quarter == Q2) &&
                (bit_idx_q == '0) && sda_sync_q[1]) begin
                ack_err_q <= 1'b1;
            end
        end
    end

    assign ack_err = ack_err_q;
`else
    assign ack_err = 1'b0;
`endif

endmodule
